pipe_ctrl_unit: RTL and testbench
=================================

# pipe_ctrl_unit

Pipelined control and hazard unit for the 5-stage MIPS core. It decodes the instruction held in IF/ID and carries the resulting control bundle through its own ID/EX, EX/MEM and MEM/WB control registers. It also detects load-use hazards and inserts bubbles, resolves branches in EX and jumps in ID with the matching flushes, and drives the EX-stage forwarding muxes. Datapath registers stay in the datapath; this block owns only control state.

## Interface
- `REG_AW`, 5: register index width.
- `ALUOP_W`, 6: ALU opcode width, must be >= 6. The func/ALU code sits zero-extended in the low 6 bits.
- `EXT_OPS`, 1: when 1, ADDI and BEQ are decoded. When 0, they are treated as illegal.

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `id_op`, in, 6: opcode of the IF/ID instruction.
- `id_func`, in, 6: func field of the IF/ID instruction.
- `id_rs`, `id_rt`, `id_rd`, in, REG_AW: source and destination indices of the IF/ID instruction.
- `ex_zero`, in, 1: ALU zero flag for the instruction currently in EX.
- `pc_en`, out, 1: PC write enable.
- `ifid_en`, out, 1: IF/ID write enable.
- `ifid_flush`, out, 1: loads a NOP into IF/ID at the next edge.
- `jump`, out, 1: selects the jump target for the PC (decided in ID).
- `branch_taken`, out, 1: selects the branch target for the PC (decided in EX).
- `ex_alu_op`, out, ALUOP_W: ALU operation in EX.
- `ex_alu_src_a`, `ex_alu_src_b`, out, 1: ALU source selects in EX.
- `fwd_a`, `fwd_b`, out, 2: forwarding select. 00 = register file, 10 = EX/MEM, 01 = MEM/WB.
- `mem_mem_write`, out, 1: data-memory write enable in MEM.
- `wb_reg_write`, out, 1: register-file write enable in WB.
- `wb_mem_to_reg`, out, 1: WB source select, memory vs ALU.
- `wb_dst`, out, REG_AW: destination register index in WB.
- `ex_illegal`, out, 1: the instruction in EX had an undecodable opcode or func.

## Operation

**Opcodes.** OPE = 000000, LW = 100011, SW = 101011, BNE = 000101, J = 000010, BEQ = 000100, ADDI = 001000. ALU codes: ADD = 100000, SUB = 100010, SLL func = 000000.

**Decode (ID, combinational).** The control bundle for each instruction class is:
- OPE: RegWrite = 1, RegDst = rd, AluOP = func. AluSrcA = 1 only when func = SLL.
- LW: RegWrite = 1, MemToReg = 1, AluSrcB = 1, AluOP = ADD, destination = rt.
- SW: MemWrite = 1, AluSrcB = 1, AluOP = ADD.
- BNE / BEQ: BranchNe / BranchEq, AluOP = SUB.
- ADDI: RegWrite = 1, AluSrcB = 1, AluOP = ADD, destination = rt.
- J: Jump = 1, no other effects.
- Any other opcode: all-zero bundle, with illegal = 1 carried to EX.

**Register-0 rule.** A destination of register 0 forces RegWrite = 0 in the bundle.

**Use of rt.** rt counts as a source operand for OPE, SW, BNE and BEQ.

**Load-use stall.** The stall condition is: ID/EX holds an LW, its destination is non-zero, and that destination equals id_rs, or equals id_rt when rt is a source. While stalled:
- `pc_en` = 0 and `ifid_en` = 0.
- The ID/EX control register loads an all-zero bubble.

**Jump.** When the IF/ID instruction is J and there is no stall and no taken branch:
- `jump` = 1 and `ifid_flush` = 1.
- J itself enters ID/EX as a bubble.

**Branch.** `branch_taken` = (ex BranchNe and not `ex_zero`) or (ex BranchEq and `ex_zero`). When it is 1:
- `ifid_flush` = 1.
- The ID/EX control register loads a bubble.
- `jump` is forced to 0.

**Priority.** branch_taken > stall > jump. A taken branch overrides a simultaneous load-use stall: `pc_en` = 1 and `ifid_en` = 1.

**Forwarding (fwd_a).** `fwd_a` = 10 when EX/MEM RegWrite = 1 and EX/MEM dst = ID/EX rs (dst is non-zero by the register-0 rule). Otherwise it is 01 on the same test against MEM/WB. Otherwise it is 00. EX/MEM wins when both stages match.

**Forwarding (fwd_b).** Same rules against ID/EX rt, applied only when the ID/EX instruction uses rt. Otherwise `fwd_b` = 00.

**Pipeline advance.** The EX/MEM and MEM/WB control registers advance every cycle. They never stall.

## Timing
- **Reset.** While `rst_n` is low, all three control registers are cleared to bubble: every registered output is 0, `wb_dst` = 0, `ex_illegal` = 0. Reset takes effect immediately, without waiting for `clk`.
- **Outputs during reset.** The combinational outputs evaluate with empty EX: `pc_en` = 1, `ifid_en` = 1, `branch_taken` = 0. `jump` and `ifid_flush` follow the `id_op` decode.
- **Reset mid-operation.** Any in-flight instruction is lost. No partial write may appear after `rst_n` rises.
- **Latency.** An instruction decoded in cycle N appears on the EX outputs in N+1, on `mem_mem_write` in N+2, and on the `wb_*` outputs in N+3.
- **Stall, jump and branch timing.**
  - `pc_en`, `ifid_en`, `ifid_flush`, `jump`, `branch_taken` and `fwd_*` are combinational in the same cycle as their cause.
  - A load-use hazard costs exactly 1 bubble cycle.
  - A jump costs 1 cycle.
  - A taken branch costs 2 cycles.
- **Repeat stall.** Back-to-back LW followed by a dependent LW stalls once per hazard. The stall never repeats for the same pair.

## Test plan
- **Reset.** Pulse `rst_n` low mid-stream with LW in EX. Required: `wb_reg_write`, `mem_mem_write` and `ex_alu_op` go to 0 immediately, and `pc_en` = 1 after release.
- **Load-use stall.** LW r2 then OPE ADD r3 = r2 + r4. Required: `pc_en` = 0 and `ifid_en` = 0 for exactly 1 cycle; the bubble in EX has `ex_alu_op` = 0; ADD then proceeds with `fwd_a` = 01.
- **Forwarding.** ADD r5, then SUB with r5 as rs and rt. Required: `fwd_a` = `fwd_b` = 10 in the SUB EX cycle. With one independent instruction in between, both are 01. With destination r0, both are 00 and `wb_reg_write` = 0.
- **Branch.** BNE in EX with `ex_zero` = 0. Required: `branch_taken` = 1, `ifid_flush` = 1, and the next EX is a bubble. Repeat with `ex_zero` = 1: no flush. Repeat with BEQ (`EXT_OPS` = 1): inverse behaviour.
- **Branch vs jump.** J in ID in the same cycle as a taken BNE in EX. Required: `jump` = 0, `branch_taken` = 1.
- **Illegal opcode.** Opcode 111111, and ADDI with `EXT_OPS` = 0. Required: `ex_illegal` = 1 for 1 cycle with all other EX, MEM and WB controls at 0.

Source files
------------

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: decode, ID/EX/MEM/WB control pipeline, load-use hazard,
// branch/jump flush and EX-stage forwarding selects for the 5-stage core.
module pipe_ctrl_unit #(
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 6,
  parameter bit EXT_OPS = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         id_op,
  input  logic [5:0]         id_func,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               ex_zero,
  output logic               pc_en,
  output logic               ifid_en,
  output logic               ifid_flush,
  output logic               jump,
  output logic               branch_taken,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_alu_src_a,
  output logic               ex_alu_src_b,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b,
  output logic               mem_mem_write,
  output logic               wb_reg_write,
  output logic               wb_mem_to_reg,
  output logic [REG_AW-1:0]  wb_dst,
  output logic               ex_illegal
);

  localparam logic [5:0] OP_OPE  = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SLL  = 6'b000000;

  // ID/EX bundle also keeps rs/rt so forwarding can be resolved in EX.
  typedef struct packed {
    logic               reg_write;
    logic               mem_to_reg;
    logic               mem_write;
    logic               alu_src_a;
    logic               alu_src_b;
    logic               br_ne;
    logic               br_eq;
    logic               uses_rt;
    logic               illegal;
    logic [ALUOP_W-1:0] alu_op;
    logic [REG_AW-1:0]  dst;
    logic [REG_AW-1:0]  rs;
    logic [REG_AW-1:0]  rt;
  } idex_t;

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_write;
    logic [REG_AW-1:0] dst;
  } exmem_t;

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic [REG_AW-1:0] dst;
  } memwb_t;

  idex_t  dec, idex_d, idex_q;
  exmem_t exmem_d, exmem_q;
  memwb_t memwb_d, memwb_q;
  logic   id_is_j, ld_use, stall;

  // Decode the IF/ID instruction into a control bundle; unknown encodings
  // become an all-zero bundle tagged illegal.
  always_comb begin
    dec     = '0;
    id_is_j = 1'b0;
    case (id_op)
      OP_OPE: begin
        if (id_func == FN_ADD || id_func == FN_SUB || id_func == FN_SLL) begin
          dec.reg_write = 1'b1;
          dec.dst       = id_rd;
          dec.alu_op    = ALUOP_W'(id_func);
          dec.alu_src_a = (id_func == FN_SLL);
          dec.uses_rt   = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_LW: begin
        dec.reg_write  = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.alu_src_b  = 1'b1;
        dec.alu_op     = ALUOP_W'(FN_ADD);
        dec.dst        = id_rt;
      end
      OP_SW: begin
        dec.mem_write = 1'b1;
        dec.alu_src_b = 1'b1;
        dec.alu_op    = ALUOP_W'(FN_ADD);
        dec.uses_rt   = 1'b1;
      end
      OP_BNE: begin
        dec.br_ne   = 1'b1;
        dec.alu_op  = ALUOP_W'(FN_SUB);
        dec.uses_rt = 1'b1;
      end
      OP_BEQ: begin
        if (EXT_OPS) begin
          dec.br_eq   = 1'b1;
          dec.alu_op  = ALUOP_W'(FN_SUB);
          dec.uses_rt = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_ADDI: begin
        if (EXT_OPS) begin
          dec.reg_write = 1'b1;
          dec.alu_src_b = 1'b1;
          dec.alu_op    = ALUOP_W'(FN_ADD);
          dec.dst       = id_rt;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_J:    id_is_j = 1'b1;
      default: dec.illegal = 1'b1;
    endcase
    if (!dec.illegal && !id_is_j) begin
      dec.rs = id_rs;
      dec.rt = id_rt;
    end
    // r0 is never written, so a zero destination disables the write
    if (dec.dst == '0) dec.reg_write = 1'b0;
  end

  // Hazard resolution: taken branch beats load-use stall beats jump.
  always_comb begin
    branch_taken = (idex_q.br_ne & ~ex_zero) | (idex_q.br_eq & ex_zero);
    // reg_write already implies a non-zero destination
    ld_use = idex_q.mem_to_reg & idex_q.reg_write &
             ((idex_q.dst == id_rs) | (dec.uses_rt & (idex_q.dst == id_rt)));
    stall      = ld_use & ~branch_taken;
    jump       = id_is_j & ~stall & ~branch_taken;
    ifid_flush = branch_taken | jump;
    pc_en      = ~stall;
    ifid_en    = ~stall;
    idex_d     = (stall | branch_taken | id_is_j) ? '0 : dec;
  end

  // EX-stage forwarding; the nearer EX/MEM producer wins.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (exmem_q.reg_write && exmem_q.dst == idex_q.rs)      fwd_a = 2'b10;
    else if (memwb_q.reg_write && memwb_q.dst == idex_q.rs) fwd_a = 2'b01;
    if (idex_q.uses_rt) begin
      if (exmem_q.reg_write && exmem_q.dst == idex_q.rt)      fwd_b = 2'b10;
      else if (memwb_q.reg_write && memwb_q.dst == idex_q.rt) fwd_b = 2'b01;
    end
  end

  // Downstream stages only carry what MEM and WB still need.
  always_comb begin
    exmem_d = '{reg_write: idex_q.reg_write, mem_to_reg: idex_q.mem_to_reg,
                mem_write: idex_q.mem_write, dst: idex_q.dst};
    memwb_d = '{reg_write: exmem_q.reg_write, mem_to_reg: exmem_q.mem_to_reg,
                dst: exmem_q.dst};
  end

  // Control pipeline registers; reset flushes every stage to a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  assign ex_alu_op     = idex_q.alu_op;
  assign ex_alu_src_a  = idex_q.alu_src_a;
  assign ex_alu_src_b  = idex_q.alu_src_b;
  assign ex_illegal    = idex_q.illegal;
  assign mem_mem_write = exmem_q.mem_write;
  assign wb_reg_write  = memwb_q.reg_write;
  assign wb_mem_to_reg = memwb_q.mem_to_reg;
  assign wb_dst        = memwb_q.dst;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Randomized bench for pipe_ctrl_unit: two instances (EXT_OPS 0 and 1) share
// one instruction stream and are each compared against an instruction-level
// pipeline model.
module tb_pipe_ctrl_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [5:0] id_op, id_func;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       ex_zero;

  logic       pc_en[2], ifid_en[2], ifid_flush[2], jump[2], branch_taken[2];
  logic       ex_sa[2], ex_sb[2], mem_mw[2], wb_rw[2], wb_m2r[2], ex_ill[2];
  logic [5:0] ex_alu_op[2];
  logic [1:0] fwd_a[2], fwd_b[2];
  logic [4:0] wb_dst[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    pipe_ctrl_unit #(.REG_AW(5), .ALUOP_W(6), .EXT_OPS(g == 1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .id_op(id_op), .id_func(id_func), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .ex_zero(ex_zero),
      .pc_en(pc_en[g]), .ifid_en(ifid_en[g]), .ifid_flush(ifid_flush[g]),
      .jump(jump[g]), .branch_taken(branch_taken[g]),
      .ex_alu_op(ex_alu_op[g]), .ex_alu_src_a(ex_sa[g]), .ex_alu_src_b(ex_sb[g]),
      .fwd_a(fwd_a[g]), .fwd_b(fwd_b[g]),
      .mem_mem_write(mem_mw[g]), .wb_reg_write(wb_rw[g]), .wb_mem_to_reg(wb_m2r[g]),
      .wb_dst(wb_dst[g]), .ex_illegal(ex_ill[g])
    );
  end

  localparam int ADD = 32, SUB = 34, SLL = 0;
  localparam int LW = 35, SW = 43, BNE = 5, BEQ = 4, ADDI = 8, JMP = 2;

  // One in-flight instruction as the spec describes it.
  typedef struct {
    bit rw, m2r, mw, sa, sb, bne, beq, urt, ill;
    int op, dst, rs, rt;
  } ins_t;

  ins_t ex_m[2], mem_m[2], wb_m[2];
  int   total = 0, bad = 0;
  bit   hold, flush;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic ins_t nop_ins();
    ins_t z = '{default: 0};
    return z;
  endfunction

  function automatic ins_t dec(int op, int fn, int rs, int rt, int rd, bit ext);
    ins_t d = '{default: 0};
    case (op)
      0:    if (fn == ADD || fn == SUB || fn == SLL) begin
              d.rw = 1; d.dst = rd; d.op = fn; d.sa = (fn == SLL); d.urt = 1;
            end else d.ill = 1;
      LW:   begin d.rw = 1; d.m2r = 1; d.sb = 1; d.op = ADD; d.dst = rt; end
      SW:   begin d.mw = 1; d.sb = 1; d.op = ADD; d.urt = 1; end
      BNE:  begin d.bne = 1; d.op = SUB; d.urt = 1; end
      BEQ:  if (ext) begin d.beq = 1; d.op = SUB; d.urt = 1; end else d.ill = 1;
      ADDI: if (ext) begin d.rw = 1; d.sb = 1; d.op = ADD; d.dst = rt; end else d.ill = 1;
      JMP:  ;
      default: d.ill = 1;
    endcase
    if (!d.ill && op != JMP) begin d.rs = rs; d.rt = rt; end
    if (d.dst == 0) d.rw = 0;
    return d;
  endfunction

  function automatic void eval(input int k, output ins_t d, output bit tk,
                               output bit st, output bit jp);
    ins_t e = ex_m[k];
    d  = dec(id_op, id_func, id_rs, id_rt, id_rd, k == 1);
    tk = (e.bne && !ex_zero) || (e.beq && ex_zero);
    st = !tk && e.m2r && e.rw && (e.dst == id_rs || (d.urt && e.dst == id_rt));
    jp = (id_op == JMP) && !st && !tk;
  endfunction

  function automatic int fw(int k, int r);
    if (mem_m[k].rw && mem_m[k].dst == r) return 2;
    if (wb_m[k].rw && wb_m[k].dst == r) return 1;
    return 0;
  endfunction

  task automatic check_dut(int k);
    ins_t d; bit tk, st, jp;
    eval(k, d, tk, st, jp);
    chk($sformatf("pc_en%0d", k), pc_en[k], !st);
    chk($sformatf("ifid_en%0d", k), ifid_en[k], !st);
    chk($sformatf("flush%0d", k), ifid_flush[k], tk || jp);
    chk($sformatf("jump%0d", k), jump[k], jp);
    chk($sformatf("taken%0d", k), branch_taken[k], tk);
    chk($sformatf("alu_op%0d", k), ex_alu_op[k], ex_m[k].op);
    chk($sformatf("src_a%0d", k), ex_sa[k], ex_m[k].sa);
    chk($sformatf("src_b%0d", k), ex_sb[k], ex_m[k].sb);
    chk($sformatf("illegal%0d", k), ex_ill[k], ex_m[k].ill);
    chk($sformatf("fwd_a%0d", k), fwd_a[k], fw(k, ex_m[k].rs));
    chk($sformatf("fwd_b%0d", k), fwd_b[k], ex_m[k].urt ? fw(k, ex_m[k].rt) : 0);
    chk($sformatf("mem_write%0d", k), mem_mw[k], mem_m[k].mw);
    chk($sformatf("wb_rw%0d", k), wb_rw[k], wb_m[k].rw);
    chk($sformatf("wb_m2r%0d", k), wb_m2r[k], wb_m[k].m2r);
    chk($sformatf("wb_dst%0d", k), wb_dst[k], wb_m[k].dst);
  endtask

  task automatic clear_models();
    for (int k = 0; k < 2; k++) begin
      ex_m[k] = nop_ins(); mem_m[k] = nop_ins(); wb_m[k] = nop_ins();
    end
    hold = 0; flush = 0;
  endtask

  // Check at the falling edge, then advance the model over the rising edge.
  task automatic tick();
    ins_t nx[2]; ins_t d; bit tk, st, jp;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_dut(k);
      eval(k, d, tk, st, jp);
      nx[k] = (tk || st || id_op == JMP) ? nop_ins() : d;
      if (k == 1) begin hold = st; flush = tk || jp; end
    end
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      wb_m[k] = mem_m[k]; mem_m[k] = ex_m[k]; ex_m[k] = nx[k];
    end
  endtask

  // Asynchronous reset pulse in the middle of a cycle.
  task automatic mid_reset();
    @(negedge clk);
    for (int k = 0; k < 2; k++) check_dut(k);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wb_rw", wb_rw[1], 0);
    chk("rst_mem_write", mem_mw[1], 0);
    chk("rst_alu_op", ex_alu_op[1], 0);
    clear_models();
    for (int k = 0; k < 2; k++) check_dut(k);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1 chk("rst_pc_en", pc_en[1], 1);
  endtask

  task automatic drive(int op, int fn, int rs, int rt, int rd);
    id_op = 6'(op); id_func = 6'(fn); id_rs = 5'(rs); id_rt = 5'(rt); id_rd = 5'(rd);
  endtask

  task automatic rand_instr();
    int r = $urandom_range(0, 99);
    int f = $urandom_range(0, 2);
    int op;
    if (r < 35)      op = 0;
    else if (r < 55) op = LW;
    else if (r < 65) op = SW;
    else if (r < 73) op = BNE;
    else if (r < 81) op = BEQ;
    else if (r < 89) op = ADDI;
    else if (r < 95) op = JMP;
    else             op = r[0] ? 63 : 12;
    drive(op, f == 0 ? ADD : (f == 1 ? SUB : SLL),
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
  endtask

  initial begin
    rst_n = 1'b0;
    ex_zero = 1'b0;
    drive(0, 0, 0, 0, 0);
    clear_models();
    @(posedge clk); @(posedge clk); #1;
    for (int k = 0; k < 2; k++) check_dut(k);
    rst_n = 1'b1;

    // LW r1, SW, LW r2, then reset with LW in EX, SW in MEM, LW r1 in WB
    drive(LW, 0, 0, 1, 0);  tick();
    drive(SW, 0, 0, 0, 0);  tick();
    drive(LW, 0, 0, 2, 0);  tick();
    drive(0, 0, 0, 0, 0);
    mid_reset();

    // LW r2 then ADD r3 = r2 + r4: one bubble, then forward from MEM/WB
    drive(LW, 0, 0, 2, 0);     tick();
    drive(0, ADD, 2, 4, 3);    tick();
    chk("lu_bubble_op", ex_alu_op[1], 0);
    tick();
    drive(0, 0, 0, 0, 0);      tick();

    for (int i = 0; i < 3000; i++) begin
      ex_zero = 1'($urandom_range(0, 1));
      if (i == 1500) mid_reset();
      else tick();
      if (flush)      drive(0, 0, 0, 0, 0);
      else if (!hold) rand_instr();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
